// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - sweeps a 2-input gate through all four input vectors and checks its output
// Each vector is held for HOLD_CYCLES, sampled once, and mismatches accumulate in fail_mask.
module gate_sweep_ctrl #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter logic [3:0]  EXPECT      = 4'b0111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [7:0] run_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  // Counter counts down to zero, so DRIVE spans HOLD_CYCLES cycles from a load of HOLD_CYCLES-1.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t      state_q;
  logic [1:0]  vec_q;
  logic [7:0]  hold_q;
  logic [1:0]  ab_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [3:0]  fail_mask_q;
  logic [7:0]  run_count_q;
  logic [3:0]  fail_mask_d;

  always_comb begin
    fail_mask_d = fail_mask_q;
    if (y_in != EXPECT[vec_q]) fail_mask_d[vec_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= 2'd0;
      hold_q      <= 8'd0;
      ab_q        <= 2'b00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'd0;
      run_count_q <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q     <= DRIVE;
            vec_q       <= 2'd0;
            hold_q      <= HOLD_LOAD;
            ab_q        <= 2'b00;
            busy_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_mask_q <= 4'd0;
          end
        end
        DRIVE: begin
          if (abort) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            hold_q  <= 8'd0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (hold_q == 8'd0) begin
            state_q <= SAMPLE;
          end else begin
            hold_q <= hold_q - 8'd1;
          end
        end
        SAMPLE: begin
          // Abort wins over the sample, so the aborted vector leaves no mark in fail_mask.
          if (abort) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            hold_q  <= 8'd0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            fail_mask_q <= fail_mask_d;
            if (vec_q == 2'd3) begin
              state_q     <= DONE;
              done_q      <= 1'b1;
              pass_q      <= (fail_mask_d == 4'd0);
              run_count_q <= run_count_q + 8'd1;
              ab_q        <= 2'b00;
            end else begin
              state_q <= DRIVE;
              vec_q   <= vec_q + 2'd1;
              ab_q    <= vec_q + 2'd1;
              hold_q  <= HOLD_LOAD;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          vec_q   <= 2'd0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_out     = ab_q[1];
  assign b_out     = ab_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign run_count = run_count_q;

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 2: settle cycles per input vector before sampling; legal range 1..255.
REQ-002 The block SHALL have parameter EXPECT, default 4'b0111: the expected gate output, where bit i is the expected y for {a,b}=i (NAND truth table).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL change on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start, input, 1 bit: request to begin a sweep.
REQ-006 Port abort, input, 1 bit: cancel a sweep in progress.
REQ-007 Port y_in, input, 1 bit: output of the gate under control.
REQ-008 Ports a_out and b_out, output, 1 bit each: gate input drive, registered.
REQ-009 Port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-011 Port pass, output, 1 bit: result of the last completed sweep.
REQ-012 Port fail_mask, output, 4 bits: bit i set when vector i mismatched.
REQ-013 Port run_count, output, 8 bits: number of completed sweeps.

Function
REQ-014 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and DONE, with a 2-bit vector index vec and a hold counter.
REQ-015 IDLE behaviour:
- start=1 and abort=0 at an edge -> DRIVE, with vec=0 and {a_out,b_out}=2'b00 valid after that edge.
- On this same edge, fail_mask SHALL clear to 0 and pass SHALL clear to 0.
REQ-016 DRIVE SHALL last exactly HOLD_CYCLES cycles, then go to SAMPLE; a_out and b_out SHALL hold {vec} throughout.
REQ-017 SAMPLE SHALL last one cycle. At its closing edge:
- y_in SHALL be compared with EXPECT[vec]; on mismatch, fail_mask[vec] SHALL be set.
- If vec<3: vec increments, {a_out,b_out} becomes the new vec, and the next state is DRIVE.
- If vec=3: the next state is DONE.
REQ-018 DONE SHALL last one cycle. During DONE:
- done=1.
- pass SHALL equal 1 if the final fail_mask (including the vec=3 result) is 0, else 0.
- run_count SHALL increment by 1, wrapping 255->0.
- {a_out,b_out} SHALL return to 00.
The next state SHALL be IDLE.
REQ-019 Latency: with the start edge as E0, done SHALL be high in the cycle following edge E0+4*(HOLD_CYCLES+1).
REQ-020 busy SHALL be 1 exactly in DRIVE, SAMPLE and DONE.
REQ-021 start SHALL be ignored while busy=1; no restart and no queuing.
REQ-022 abort=1 at an edge in DRIVE or SAMPLE SHALL produce all of the following:
- IDLE next cycle.
- {a_out,b_out}=00.
- busy=0.
- No done pulse and no run_count increment.
- pass=0; fail_mask holds the partial results.
REQ-023 abort=1 in DONE SHALL have no effect; the sweep completes normally.
REQ-024 When start and abort are both high in IDLE, abort SHALL win and the state SHALL remain IDLE.
REQ-025 pass and fail_mask SHALL hold their values from sweep completion until the next accepted start.
REQ-026 The hold counter SHALL be wide enough for 255 and SHALL reload on every entry to DRIVE.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for clk, force the following:
- State IDLE, vec=0, hold counter 0.
- a_out=0, b_out=0.
- busy=0, done=0, pass=0.
- fail_mask=0, run_count=0.
REQ-028 A reset asserted mid-sweep SHALL discard the sweep; after release, the block SHALL accept a new start on the first edge.

Verification (HOLD_CYCLES=2, EXPECT=4'b0111)
REQ-029 Correct NAND model, start pulse -> {a,b} steps 00,01,10,11 for 3 cycles each; done at E0+12; pass=1, fail_mask=0000, run_count=1.
REQ-030 y_in stuck at 1 -> pass=0, fail_mask=1000.
REQ-031 abort asserted 5 cycles after start -> IDLE next cycle, no done pulse, run_count unchanged, pass=0, a/b=00.
REQ-032 start re-pulsed while busy, then start and abort together in IDLE -> neither starts a sweep; one done for the original sweep only.
REQ-033 rst_n pulsed low asynchronously mid-DRIVE -> all outputs 0 before the next edge; a new start after release completes with pass=1.
REQ-034 256 back-to-back passing sweeps -> run_count wraps to 0; pass=1 after each sweep.
